odo_round_key_seq: RTL

Parametrised round-key sequencer for the Odo hashing core. It replaces a fixed per-period key ROM with a key table that software can load. On request it streams the keys for one full hash, in forward or reverse round order, to the round pipeline over a valid/ready handshake. It sits between the epoch configuration interface and the Odo round datapath.

---
 rtl/odo_round_key_seq_pkg.sv | 17 +
 rtl/odo_round_key_seq_if.sv | 33 +++
 rtl/odo_round_key_seq_key_table.sv | 33 +++
 rtl/odo_round_key_seq.sv | 108 ++++++++++
 4 files changed

// File: rtl/odo_round_key_seq_pkg.sv
// Shared constants and state/order encodings for the Odo round-key sequencer.
package odo_pkg;

    localparam int ODO_KEY_W  = 10;
    localparam int ODO_ROUNDS = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        ORDER_FWD = 1'b0,
        ORDER_REV = 1'b1
    } order_e;

endpackage

// File: rtl/odo_round_key_seq_if.sv
// Config-write and key-stream bus between the epoch config side, the round pipeline and the sequencer.
interface odo_round_key_seq_if
    import odo_pkg::*;
#(
    parameter int KEY_W = ODO_KEY_W,
    parameter int IDX_W = $clog2(ODO_ROUNDS)
);

    logic             cfg_we;
    logic [IDX_W-1:0] cfg_addr;
    logic [KEY_W-1:0] cfg_data;
    logic             cfg_err;
    logic             start;
    logic             reverse;
    logic             busy;
    logic [KEY_W-1:0] key;
    logic [IDX_W-1:0] key_idx;
    logic             key_valid;
    logic             key_ready;
    logic             key_last;
    logic             done;

    modport master (
        output cfg_we, cfg_addr, cfg_data, start, reverse, key_ready,
        input  cfg_err, busy, key, key_idx, key_valid, key_last, done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, reverse, key_ready,
        output cfg_err, busy, key, key_idx, key_valid, key_last, done
    );

endinterface

// File: rtl/odo_round_key_seq_key_table.sv
// Software-loadable round-key register file: one synchronous write port, one asynchronous read port.
module odo_key_table
    import odo_pkg::*;
#(
    parameter int KEY_W  = ODO_KEY_W,
    parameter int ROUNDS = ODO_ROUNDS,
    parameter int IDX_W  = $clog2(ROUNDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [KEY_W-1:0] i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [KEY_W-1:0] o_rdata
);

    logic [KEY_W-1:0] r_mem [ROUNDS];

    // Caller guarantees both addresses stay below ROUNDS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROUNDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/odo_round_key_seq.sv
// Round-key sequencer: streams one hash worth of table keys, forward or reverse, over valid/ready.
module odo_round_key_seq
    import odo_pkg::*;
#(
    parameter int KEY_W  = ODO_KEY_W,
    parameter int ROUNDS = ODO_ROUNDS,
    parameter int IDX_W  = $clog2(ROUNDS)
) (
    input  logic               clk,
    input  logic               rst_n,
    odo_round_key_seq_if.slave bus
);

    localparam logic [0:0]       S_IDLE   = 1'(IDLE);
    localparam logic [0:0]       S_RUN    = 1'(RUN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W:0]   DEPTH    = (IDX_W + 1)'(ROUNDS);

    logic [0:0]       r_state;
    order_e           r_order;
    logic [IDX_W-1:0] r_idx;
    logic [KEY_W-1:0] r_key;
    logic             r_valid;
    logic             r_last;
    logic             r_done;
    logic             r_cfgErr;

    logic             w_idle;
    logic             w_wrEn;
    logic             w_hs;
    logic [IDX_W-1:0] w_nextIdx;
    logic [IDX_W-1:0] w_rdAddr;
    logic [KEY_W-1:0] w_rdData;
    logic             w_curLast;
    logic             w_nextLast;

    assign w_idle    = (r_state == S_IDLE);
    assign w_wrEn    = bus.cfg_we && w_idle && ({1'b0, bus.cfg_addr} < DEPTH);
    assign w_hs      = r_valid && bus.key_ready;
    assign w_nextIdx = (r_order == ORDER_REV) ? r_idx - 1'b1 : r_idx + 1'b1;

    // Look ahead to the next round only while a non-terminal key is showing, so the read never leaves the table.
    assign w_rdAddr   = (r_valid && !r_last) ? w_nextIdx : r_idx;
    assign w_curLast  = (r_order == ORDER_REV) ? (r_idx == '0) : (r_idx == LAST_IDX);
    assign w_nextLast = (r_order == ORDER_REV) ? (w_nextIdx == '0) : (w_nextIdx == LAST_IDX);

    odo_key_table #(
        .KEY_W (KEY_W),
        .ROUNDS(ROUNDS),
        .IDX_W (IDX_W)
    ) u_table (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_wrEn),
        .i_waddr(bus.cfg_addr),
        .i_wdata(bus.cfg_data),
        .i_raddr(w_rdAddr),
        .o_rdata(w_rdData)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_order  <= ORDER_FWD;
            r_idx    <= '0;
            r_key    <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
            r_cfgErr <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_cfgErr <= bus.cfg_we && !w_wrEn;
            if (r_state == S_IDLE) begin
                if (bus.start) begin
                    r_state <= S_RUN;
                    r_order <= bus.reverse ? ORDER_REV : ORDER_FWD;
                    r_idx   <= bus.reverse ? LAST_IDX : '0;
                end
            end else if (!r_valid) begin
                // First RUN cycle: the table already holds any write that arrived alongside start.
                r_valid <= 1'b1;
                r_key   <= w_rdData;
                r_last  <= w_curLast;
            end else if (w_hs) begin
                if (r_last) begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_idx  <= w_nextIdx;
                    r_key  <= w_rdData;
                    r_last <= w_nextLast;
                end
            end
        end
    end

    assign bus.busy      = (r_state == S_RUN);
    assign bus.key       = r_key;
    assign bus.key_idx   = r_idx;
    assign bus.key_valid = r_valid;
    assign bus.key_last  = r_last;
    assign bus.done      = r_done;
    assign bus.cfg_err   = r_cfgErr;

endmodule
